// File: rtl/mkio_manchester_tx.sv
// mkio_manchester_tx: MIL-STD-1553 Manchester II word serialiser with one-word holding register
module mkio_manchester_tx #(
    parameter int HALF_BIT_CLKS = 24
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tx_ready,
    input  logic [15:0] tx_data,
    input  logic        tx_cd,
    output logic        tx_busy,
    output logic        tx_active,
    output logic        tx_done,
    output logic        tx_p,
    output logic        tx_n,
    output logic        tx_inh
);
    typedef enum logic {IDLE, SEND} state_t;

    localparam logic [7:0] CNT_LAST = 8'(HALF_BIT_CLKS - 1);
    localparam logic [5:0] H_LAST   = 6'd39;

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [5:0]  h_q, h_d;
    logic [15:0] data_q, data_d;
    logic [15:0] hold_data_q, hold_data_d;
    logic        cd_q, cd_d;
    logic        hold_cd_q, hold_cd_d;
    logic        hold_full_q, hold_full_d;
    logic        done_q, done_d;
    logic        half_end, word_end, load_pt, level;

    assign half_end = cnt_q == CNT_LAST;
    assign word_end = state_q == SEND && half_end && h_q == H_LAST;
    assign load_pt  = state_q == IDLE || word_end;

    // State register; reset drops the line and discards both the partial and the held word.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            h_q         <= '0;
            data_q      <= '0;
            cd_q        <= 1'b0;
            hold_data_q <= '0;
            hold_cd_q   <= 1'b0;
            hold_full_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            h_q         <= h_d;
            data_q      <= data_d;
            cd_q        <= cd_d;
            hold_data_q <= hold_data_d;
            hold_cd_q   <= hold_cd_d;
            hold_full_q <= hold_full_d;
            done_q      <= done_d;
        end
    end

    // Next state: half-bit timing, word load at IDLE or the end of h=39, holding capture otherwise.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        h_d         = h_q;
        data_d      = data_q;
        cd_d        = cd_q;
        hold_data_d = hold_data_q;
        hold_cd_d   = hold_cd_q;
        hold_full_d = hold_full_q;
        done_d      = word_end;
        if (state_q == SEND) begin
            cnt_d = half_end ? 8'd0 : cnt_q + 8'd1;
            h_d   = half_end ? h_q + 6'd1 : h_q;
        end
        if (load_pt) begin
            cnt_d = '0;
            h_d   = '0;
            if (hold_full_q) begin
                state_d     = SEND;
                data_d      = hold_data_q;
                cd_d        = hold_cd_q;
                hold_full_d = 1'b0;
            end else if (tx_ready) begin
                state_d = SEND;
                data_d  = tx_data;
                cd_d    = tx_cd;
            end else begin
                state_d = IDLE;
            end
        end else if (tx_ready && !hold_full_q) begin
            hold_data_d = tx_data;
            hold_cd_d   = tx_cd;
            hold_full_d = 1'b1;
        end
    end

    // Line level of the current half bit: sync, MSB-first Manchester pairs, then odd parity pair.
    always_comb begin
        level = h_q < 6'd3  ? cd_q :
                h_q < 6'd6  ? ~cd_q :
                h_q < 6'd38 ? data_q[4'((6'd37 - h_q) >> 1)] ^ h_q[0] :
                              ~^data_q ^ h_q[0];
    end

    assign tx_active = state_q == SEND;
    assign tx_p      = tx_active & level;
    assign tx_n      = tx_active & ~level;
    assign tx_inh    = ~tx_active;
    assign tx_busy   = hold_full_q;
    assign tx_done   = done_q;
endmodule
